// File: rtl/ramp_pkg.sv
// Shared definitions for the duty ramp accumulator.
//   N_DEFAULT         : default data width of value/target/step
//   ST_IDLE/RAMP/DONE : controller state encoding
package ramp_pkg;

  localparam int N_DEFAULT = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ramp_step_unit.sv
// Combinational step unit: moves value one step toward target, clamping at
// target so the ramp never overshoots.
// Ports:
//   value      in  N  current accumulator value
//   target     in  N  ramp end value
//   step       in  N  increment (non-zero, guaranteed by the caller)
//   next_value out N  clamped next value
module ramp_step_unit
  import ramp_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] value,
  input  logic [N-1:0] target,
  input  logic [N-1:0] step,
  output logic [N-1:0] next_value
);

  // Sum and difference carry one extra bit: sum[N] means the add passed
  // 2^N-1, diff[N] means the subtract went below zero. Either way the
  // clamp to target catches it.
  logic [N:0] sum;
  logic [N:0] diff;

  always_comb begin
    sum        = {1'b0, value} + {1'b0, step};
    diff       = {1'b0, value} - {1'b0, step};
    next_value = value;
    if (value < target) begin
      if (sum > {1'b0, target}) next_value = target;
      else                      next_value = sum[N-1:0];
    end else if (value > target) begin
      if (diff[N] || (diff < {1'b0, target})) next_value = target;
      else                                    next_value = diff[N-1:0];
    end
  end

endmodule

// File: rtl/duty_ramp_accumulator.sv
// Duty ramp accumulator: walks a registered PWM duty value toward a latched
// target by a latched step, one step per en strobe.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle request, latches target/step and begins a ramp
//   target   : ramp end value (sampled on start)
//   step     : increment per tick (sampled on start, 0 treated as 1)
//   en       : tick strobe
//   value    : registered accumulator value
//   busy     : high exactly while ramping
//   done     : one-cycle pulse the cycle after value reaches target
// The controller state is held in state_q (ST_IDLE/ST_RAMP/ST_DONE).
module duty_ramp_accumulator
  import ramp_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] target,
  input  logic [N-1:0] step,
  input  logic         en,
  output logic [N-1:0] value,
  output logic         busy,
  output logic         done
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_q,    state_d;
  logic [N-1:0] value_q,    value_d;
  logic [N-1:0] target_r_q, target_r_d;
  logic [N-1:0] step_r_q,   step_r_d;
  logic [N-1:0] next_value;
  logic [N-1:0] step_sel;

  ramp_step_unit #(.N(N)) u_step (
    .value      (value_q),
    .target     (target_r_q),
    .step       (step_r_q),
    .next_value (next_value)
  );

  // A zero step would stall the ramp forever, so it is promoted to 1.
  assign step_sel = (step == '0) ? ONE : step;

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    target_r_d = target_r_q;
    step_r_d   = step_r_q;
    case (state_q)
      ST_RAMP: begin
        if (start) begin
          // Retarget wins over the tick; value holds this cycle.
          target_r_d = target;
          step_r_d   = step_sel;
        end else if (value_q == target_r_q) begin
          state_d = ST_DONE;
        end else if (en) begin
          value_d = next_value;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        if (start) begin
          target_r_d = target;
          step_r_d   = step_sel;
          state_d    = (target == value_q) ? ST_DONE : ST_RAMP;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    if (rst) begin
      state_d    = ST_IDLE;
      value_d    = '0;
      target_r_d = '0;
      step_r_d   = ONE;
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    value_q    <= value_d;
    target_r_q <= target_r_d;
    step_r_q   <= step_r_d;
  end

  assign value = value_q;
  assign busy  = (state_q == ST_RAMP);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_duty_ramp_accumulator.sv
// Bench for duty_ramp_accumulator (N=5). Each driven cycle pushes the
// expected {value, busy, done} after the edge; a monitor pops and compares.
module tb_duty_ramp_accumulator;
  localparam int N = 5;
  localparam int W = N + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] target = '0;
  logic [N-1:0] step = '0;
  logic         en = 1'b0;
  logic [N-1:0] value;
  logic         busy;
  logic         done;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  duty_ramp_accumulator #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .step   (step),
    .en     (en),
    .value  (value),
    .busy   (busy),
    .done   (done)
  );

  // clock
  always #5 clk = ~clk;

  // driver: apply inputs for one cycle, then queue the expected outputs
  task automatic tick(input logic r, input logic s, input int t, input int st,
                      input logic e, input int ev, input logic eb, input logic ed);
    rst    = r;
    start  = s;
    target = t[N-1:0];
    step   = st[N-1:0];
    en     = e;
    @(posedge clk);
    #1;
    exp_q.push_back({ev[N-1:0], eb, ed});
  endtask

  // run: plain en ticks with no start
  task automatic run(input logic e, input int ev, input logic eb, input logic ed);
    tick(1'b0, 1'b0, 0, 0, e, ev, eb, ed);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_cmp++;
      if ({value, busy, done} !== exp_v) begin
        n_bad++;
        $display("FAIL out#%0d: got value=%0d busy=%0b done=%0b, want value=%0d busy=%0b done=%0b",
                 n_cmp, value, busy, done, exp_v[W-1:2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    // reset for two cycles
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0);

    // up ramp 0 -> 20 step 6
    tick(0, 1, 20, 6, 1, 0, 1, 0);
    run(1, 6, 1, 0);
    run(1, 12, 1, 0);
    run(1, 18, 1, 0);
    run(1, 20, 1, 0);
    run(1, 20, 0, 1);
    run(1, 20, 0, 0);

    // down ramp 20 -> 3 step 7
    tick(0, 1, 3, 7, 1, 20, 1, 0);
    run(1, 13, 1, 0);
    run(1, 6, 1, 0);
    run(1, 3, 1, 0);
    run(1, 3, 0, 1);
    run(1, 3, 0, 0);

    // get to 25, then ceiling ramp to 31 step 10
    tick(0, 1, 25, 22, 1, 3, 1, 0);
    run(1, 25, 1, 0);
    run(1, 25, 0, 1);
    run(0, 25, 0, 0);
    tick(0, 1, 31, 10, 1, 25, 1, 0);
    run(1, 31, 1, 0);
    run(1, 31, 0, 1);
    run(1, 31, 0, 0);

    // start with target equal to value: straight to DONE
    tick(0, 1, 31, 4, 1, 31, 0, 1);
    run(0, 31, 0, 0);

    // floor: 31 -> 0 step 20 clamps at 0
    tick(0, 1, 0, 20, 1, 31, 1, 0);
    run(1, 11, 1, 0);
    run(1, 0, 1, 0);
    run(1, 0, 0, 1);
    run(1, 0, 0, 0);

    // from 0, target 31 step 31 in one tick
    tick(0, 1, 31, 31, 1, 0, 1, 0);
    run(1, 31, 1, 0);
    run(1, 31, 0, 1);
    run(1, 31, 0, 0);

    // retarget mid-ramp
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 20, 6, 1, 0, 1, 0);
    run(1, 6, 1, 0);
    run(1, 12, 1, 0);
    tick(0, 1, 4, 5, 1, 12, 1, 0);
    run(1, 7, 1, 0);
    run(1, 4, 1, 0);
    run(1, 4, 0, 1);
    run(1, 4, 0, 0);

    // step 0 promoted to 1, en toggled 1-0-1
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 3, 0, 0, 0, 1, 0);
    run(1, 1, 1, 0);
    run(0, 1, 1, 0);
    run(1, 2, 1, 0);
    run(1, 3, 1, 0);
    run(1, 3, 0, 1);
    run(1, 3, 0, 0);

    // reset mid-ramp at value 7: abort, no done
    tick(0, 1, 20, 4, 1, 3, 1, 0);
    run(1, 7, 1, 0);
    tick(1, 1, 9, 2, 1, 0, 0, 0);
    run(1, 0, 0, 0);
    run(1, 0, 0, 0);

    // start accepted while in DONE
    tick(0, 1, 2, 2, 1, 0, 1, 0);
    run(1, 2, 1, 0);
    run(1, 2, 0, 1);
    tick(0, 1, 5, 3, 1, 2, 1, 0);
    run(1, 5, 1, 0);
    run(1, 5, 0, 1);
    run(1, 5, 0, 0);

    // let the monitor drain (bounded)
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
